sha2_compress_iter: RTL and testbench



---
 rtl/sha2_compress_iter.sv | 246 ++++++++++++++++++++++++
 tb/tb_sha2_compress_iter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_compress_iter.sv
// Iterative SHA-2 compression, one round per clock, 32- or 64-bit words by MODE.
// Build option SHA2_FEEDFORWARD_EN adds the Hsave + final per-word addition.
module sha2_compress_iter #(
    parameter int MODE = 256,
    localparam int WIDTH = (MODE == 384 || MODE == 512) ? 64 : 32,
    localparam int ROUNDS = (WIDTH == 64) ? 80 : 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [16*WIDTH-1:0] block_in,
    input  logic [8*WIDTH-1:0]  h_in,
    output logic [8*WIDTH-1:0]  h_out,
    output logic                valid,
    output logic                busy
);

    if (!(MODE == 224 || MODE == 256 || MODE == 384 || MODE == 512)) begin : g_bad_mode
        $error("sha2_compress_iter: MODE must be 224, 256, 384 or 512");
    end

    localparam int BS0_A = (WIDTH == 64) ? 28 : 2;
    localparam int BS0_B = (WIDTH == 64) ? 34 : 13;
    localparam int BS0_C = (WIDTH == 64) ? 39 : 22;
    localparam int BS1_A = (WIDTH == 64) ? 14 : 6;
    localparam int BS1_B = (WIDTH == 64) ? 18 : 11;
    localparam int BS1_C = (WIDTH == 64) ? 41 : 25;
    localparam int SS0_A = (WIDTH == 64) ? 1 : 7;
    localparam int SS0_B = (WIDTH == 64) ? 8 : 18;
    localparam int SS0_S = (WIDTH == 64) ? 7 : 3;
    localparam int SS1_A = (WIDTH == 64) ? 19 : 17;
    localparam int SS1_B = (WIDTH == 64) ? 61 : 19;
    localparam int SS1_S = (WIDTH == 64) ? 6 : 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } state_t;

    state_t           state;
    logic [6:0]       cnt;
    logic [WIDTH-1:0] v [8];
    logic [WIDTH-1:0] w [16];
`ifdef SHA2_FEEDFORWARD_EN
    logic [WIDTH-1:0] hsave [8];
`endif

    logic [WIDTH-1:0]   k_word;
    logic [WIDTH-1:0]   t1;
    logic [WIDTH-1:0]   t2;
    logic [WIDTH-1:0]   w_new;
    logic [8*WIDTH-1:0] h_next;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    function automatic logic [WIDTH-1:0] bsig0(input logic [WIDTH-1:0] x);
        return rotr(x, BS0_A) ^ rotr(x, BS0_B) ^ rotr(x, BS0_C);
    endfunction

    function automatic logic [WIDTH-1:0] bsig1(input logic [WIDTH-1:0] x);
        return rotr(x, BS1_A) ^ rotr(x, BS1_B) ^ rotr(x, BS1_C);
    endfunction

    function automatic logic [WIDTH-1:0] ssig0(input logic [WIDTH-1:0] x);
        return rotr(x, SS0_A) ^ rotr(x, SS0_B) ^ (x >> SS0_S);
    endfunction

    function automatic logic [WIDTH-1:0] ssig1(input logic [WIDTH-1:0] x);
        return rotr(x, SS1_A) ^ rotr(x, SS1_B) ^ (x >> SS1_S);
    endfunction

    // SHA-256 constants are the upper 32 bits of the SHA-512 ones
    function automatic logic [WIDTH-1:0] kt(input logic [63:0] x);
        return WIDTH'(x >> (64 - WIDTH));
    endfunction

    function automatic logic [WIDTH-1:0] k_rom(input logic [6:0] t);
        unique case (t)
            7'd0:  k_rom = kt(64'h428a2f98d728ae22);
            7'd1:  k_rom = kt(64'h7137449123ef65cd);
            7'd2:  k_rom = kt(64'hb5c0fbcfec4d3b2f);
            7'd3:  k_rom = kt(64'he9b5dba58189dbbc);
            7'd4:  k_rom = kt(64'h3956c25bf348b538);
            7'd5:  k_rom = kt(64'h59f111f1b605d019);
            7'd6:  k_rom = kt(64'h923f82a4af194f9b);
            7'd7:  k_rom = kt(64'hab1c5ed5da6d8118);
            7'd8:  k_rom = kt(64'hd807aa98a3030242);
            7'd9:  k_rom = kt(64'h12835b0145706fbe);
            7'd10: k_rom = kt(64'h243185be4ee4b28c);
            7'd11: k_rom = kt(64'h550c7dc3d5ffb4e2);
            7'd12: k_rom = kt(64'h72be5d74f27b896f);
            7'd13: k_rom = kt(64'h80deb1fe3b1696b1);
            7'd14: k_rom = kt(64'h9bdc06a725c71235);
            7'd15: k_rom = kt(64'hc19bf174cf692694);
            7'd16: k_rom = kt(64'he49b69c19ef14ad2);
            7'd17: k_rom = kt(64'hefbe4786384f25e3);
            7'd18: k_rom = kt(64'h0fc19dc68b8cd5b5);
            7'd19: k_rom = kt(64'h240ca1cc77ac9c65);
            7'd20: k_rom = kt(64'h2de92c6f592b0275);
            7'd21: k_rom = kt(64'h4a7484aa6ea6e483);
            7'd22: k_rom = kt(64'h5cb0a9dcbd41fbd4);
            7'd23: k_rom = kt(64'h76f988da831153b5);
            7'd24: k_rom = kt(64'h983e5152ee66dfab);
            7'd25: k_rom = kt(64'ha831c66d2db43210);
            7'd26: k_rom = kt(64'hb00327c898fb213f);
            7'd27: k_rom = kt(64'hbf597fc7beef0ee4);
            7'd28: k_rom = kt(64'hc6e00bf33da88fc2);
            7'd29: k_rom = kt(64'hd5a79147930aa725);
            7'd30: k_rom = kt(64'h06ca6351e003826f);
            7'd31: k_rom = kt(64'h142929670a0e6e70);
            7'd32: k_rom = kt(64'h27b70a8546d22ffc);
            7'd33: k_rom = kt(64'h2e1b21385c26c926);
            7'd34: k_rom = kt(64'h4d2c6dfc5ac42aed);
            7'd35: k_rom = kt(64'h53380d139d95b3df);
            7'd36: k_rom = kt(64'h650a73548baf63de);
            7'd37: k_rom = kt(64'h766a0abb3c77b2a8);
            7'd38: k_rom = kt(64'h81c2c92e47edaee6);
            7'd39: k_rom = kt(64'h92722c851482353b);
            7'd40: k_rom = kt(64'ha2bfe8a14cf10364);
            7'd41: k_rom = kt(64'ha81a664bbc423001);
            7'd42: k_rom = kt(64'hc24b8b70d0f89791);
            7'd43: k_rom = kt(64'hc76c51a30654be30);
            7'd44: k_rom = kt(64'hd192e819d6ef5218);
            7'd45: k_rom = kt(64'hd69906245565a910);
            7'd46: k_rom = kt(64'hf40e35855771202a);
            7'd47: k_rom = kt(64'h106aa07032bbd1b8);
            7'd48: k_rom = kt(64'h19a4c116b8d2d0c8);
            7'd49: k_rom = kt(64'h1e376c085141ab53);
            7'd50: k_rom = kt(64'h2748774cdf8eeb99);
            7'd51: k_rom = kt(64'h34b0bcb5e19b48a8);
            7'd52: k_rom = kt(64'h391c0cb3c5c95a63);
            7'd53: k_rom = kt(64'h4ed8aa4ae3418acb);
            7'd54: k_rom = kt(64'h5b9cca4f7763e373);
            7'd55: k_rom = kt(64'h682e6ff3d6b2b8a3);
            7'd56: k_rom = kt(64'h748f82ee5defb2fc);
            7'd57: k_rom = kt(64'h78a5636f43172f60);
            7'd58: k_rom = kt(64'h84c87814a1f0ab72);
            7'd59: k_rom = kt(64'h8cc702081a6439ec);
            7'd60: k_rom = kt(64'h90befffa23631e28);
            7'd61: k_rom = kt(64'ha4506cebde82bde9);
            7'd62: k_rom = kt(64'hbef9a3f7b2c67915);
            7'd63: k_rom = kt(64'hc67178f2e372532b);
            7'd64: k_rom = kt(64'hca273eceea26619c);
            7'd65: k_rom = kt(64'hd186b8c721c0c207);
            7'd66: k_rom = kt(64'heada7dd6cde0eb1e);
            7'd67: k_rom = kt(64'hf57d4f7fee6ed178);
            7'd68: k_rom = kt(64'h06f067aa72176fba);
            7'd69: k_rom = kt(64'h0a637dc5a2c898a6);
            7'd70: k_rom = kt(64'h113f9804bef90dae);
            7'd71: k_rom = kt(64'h1b710b35131c471b);
            7'd72: k_rom = kt(64'h28db77f523047d84);
            7'd73: k_rom = kt(64'h32caab7b40c72493);
            7'd74: k_rom = kt(64'h3c9ebe0a15c9bebc);
            7'd75: k_rom = kt(64'h431d67c49c100d4c);
            7'd76: k_rom = kt(64'h4cc5d4becb3e42b6);
            7'd77: k_rom = kt(64'h597f299cfc657e2a);
            7'd78: k_rom = kt(64'h5fcb6fab3ad6faec);
            7'd79: k_rom = kt(64'h6c44198c4a475817);
            default: k_rom = '0;
        endcase
    endfunction

    always_comb begin
        k_word = k_rom(cnt);
        t1 = bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + v[7] + w[0] + k_word;
        t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
        h_next = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef SHA2_FEEDFORWARD_EN
            h_next[(7-i)*WIDTH +: WIDTH] = v[i] + hsave[i];
`else
            h_next[(7-i)*WIDTH +: WIDTH] = v[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            h_out <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                v[i] <= '0;
`ifdef SHA2_FEEDFORWARD_EN
                hsave[i] <= '0;
`endif
            end
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 8; i++) begin
                            v[i] <= h_in[(7-i)*WIDTH +: WIDTH];
`ifdef SHA2_FEEDFORWARD_EN
                            hsave[i] <= h_in[(7-i)*WIDTH +: WIDTH];
`endif
                        end
                        for (int i = 0; i < 16; i++) begin
                            w[i] <= block_in[(15-i)*WIDTH +: WIDTH];
                        end
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    v[0] <= t1 + t2;
                    v[1] <= v[0];
                    v[2] <= v[1];
                    v[3] <= v[2];
                    v[4] <= v[3] + t1;
                    v[5] <= v[4];
                    v[6] <= v[5];
                    v[7] <= v[6];
                    // Rolling window: w[0] is always the current W[t]
                    for (int i = 0; i < 15; i++) begin
                        w[i] <= w[i+1];
                    end
                    w[15] <= w_new;
                    cnt   <= cnt + 7'd1;
                    if (cnt == 7'(ROUNDS - 1)) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    h_out <= h_next;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_compress_iter.sv
// Directed scoreboard bench for sha2_compress_iter (MODE 256, 512 and 224 instances).
// Expectations follow the SHA2_FEEDFORWARD_EN build option.
module tb_sha2_compress_iter;

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [511:0] ABC256 = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [1023:0] ABC512 = {64'h6162638000000000, 896'h0, 64'h18};
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG224 =
        {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
    localparam logic [255:0] M224 = {{224{1'b1}}, 32'h0};
    localparam logic [511:0] D512 = {64'hddaf35a193617aba, 384'h0, 64'h00000000a54ca49f};
    localparam logic [511:0] M512 = {64'hffffffffffffffff, 384'h0, 64'h00000000ffffffff};
    localparam logic [511:0] MSG1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] MSG2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG2 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic clk = 1'b0;
    logic rst;
    logic start, start5, start2;
    logic [511:0] block_in, blk2;
    logic [1023:0] blk5;
    logic [255:0] h_in, hin2, h_out, hout2;
    logic [511:0] hin5, hout5;
    logic valid, busy, valid5, busy5, valid2, busy2;

    int n_assert = 0;
    int n_fail = 0;
    logic [255:0] sb[$];
    logic [511:0] sb5[$];

    always #5 clk = ~clk;

    sha2_compress_iter #(.MODE(256)) dut (
        .clk(clk), .rst(rst), .start(start), .block_in(block_in),
        .h_in(h_in), .h_out(h_out), .valid(valid), .busy(busy));

    sha2_compress_iter #(.MODE(512)) u512 (
        .clk(clk), .rst(rst), .start(start5), .block_in(blk5),
        .h_in(hin5), .h_out(hout5), .valid(valid5), .busy(busy5));

    sha2_compress_iter #(.MODE(224)) u224 (
        .clk(clk), .rst(rst), .start(start2), .block_in(blk2),
        .h_in(hin2), .h_out(hout2), .valid(valid2), .busy(busy2));

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [255:0] sub8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] - y[i*32 +: 32];
        return r;
    endfunction

    // Without feed-forward the block returns digest - IV per word
    function automatic logic [255:0] exp256(input logic [255:0] d, input logic [255:0] iv);
`ifdef SHA2_FEEDFORWARD_EN
        return d;
`else
        return sub8(d, iv);
`endif
    endfunction

    function automatic logic [511:0] exp512(input logic [511:0] d, input logic [511:0] iv);
`ifdef SHA2_FEEDFORWARD_EN
        return d;
`else
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = d[i*64 +: 64] - iv[i*64 +: 64];
        return r;
`endif
    endfunction

    function automatic logic [255:0] pop256();
        if (sb.size() == 0) return '0;
        return sb.pop_front();
    endfunction

    function automatic logic [511:0] pop512();
        if (sb5.size() == 0) return '0;
        return sb5.pop_front();
    endfunction

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run256(input string tag, input logic [511:0] blk, input logic [255:0] iv,
                          input logic [255:0] dig, input int p1, input int p2);
        logic [255:0] e;
        int first;
        int nval;
        e = exp256(dig, iv);
        sb.push_back(e);
        @(negedge clk);
        block_in = blk;
        h_in = iv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        block_in = '0;
        h_in = '0;
        chk({tag, " busy"}, 1024'(busy), 1024'(1));
        first = 0;
        nval = 0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                nval++;
                if (first == 0) first = c;
                chk({tag, " h_out"}, 1024'(h_out), 1024'(pop256()));
            end
            start = (c == p1 || c == p2);
        end
        start = 1'b0;
        chk({tag, " latency"}, 1024'(first), 1024'(65));
        chk({tag, " valid count"}, 1024'(nval), 1024'(1));
        chk({tag, " busy after"}, 1024'(busy), 1024'(0));
        chk({tag, " h_out held"}, 1024'(h_out), 1024'(e));
    endtask

    initial begin
        int cyc;
        int nval;
        logic [255:0] hin_b;

        rst = 1'b1;
        start = 1'b0; start5 = 1'b0; start2 = 1'b0;
        block_in = '0; blk5 = '0; blk2 = '0;
        h_in = '0; hin5 = '0; hin2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset h_out", 1024'(h_out), 1024'(0));
        chk("reset valid", 1024'(valid), 1024'(0));
        chk("reset busy", 1024'(busy), 1024'(0));
        chk("reset h_out 512", 1024'(hout5), 1024'(0));
        rst = 1'b0;

        run256("abc", ABC256, IV256, DIG_ABC, 0, 0);

        // Two-block message with start held high across both blocks
        @(negedge clk);
        block_in = MSG1;
        h_in = IV256;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!valid && cyc < 100);
        chk("b2b first latency", 1024'(cyc), 1024'(65));
`ifdef SHA2_FEEDFORWARD_EN
        hin_b = h_out;
`else
        hin_b = add8(h_out, IV256);
`endif
        block_in = MSG2;
        h_in = hin_b;
        sb.push_back(exp256(DIG2, hin_b));
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
        end while (!valid && cyc < 100);
        start = 1'b0;
        chk("b2b spacing", 1024'(cyc), 1024'(66));
        chk("b2b digest", 1024'(h_out), 1024'(pop256()));

        // Abort a block with reset part-way through
        @(negedge clk);
        block_in = ABC256;
        h_in = IV256;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nval = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (valid) nval++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort h_out", 1024'(h_out), 1024'(0));
        chk("abort busy", 1024'(busy), 1024'(0));
        chk("abort valid", 1024'(valid), 1024'(0));
        rst = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            if (valid) nval++;
        end
        chk("abort no valid", 1024'(nval), 1024'(0));

        run256("abc after abort", ABC256, IV256, DIG_ABC, 0, 0);
        run256("abc ignored starts", ABC256, IV256, DIG_ABC, 10, 40);

        // SHA-512 instance
        sb5.push_back(exp512(D512, IV512));
        @(negedge clk);
        blk5 = ABC512;
        hin5 = IV512;
        start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        chk("sha512 busy", 1024'(busy5), 1024'(1));
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!valid5 && cyc < 120);
        chk("sha512 latency", 1024'(cyc), 1024'(81));
        chk("sha512 digest", 1024'(hout5 & M512), 1024'(pop512() & M512));

        // SHA-224 instance
        sb.push_back(exp256(DIG224, IV224));
        @(negedge clk);
        blk2 = ABC256;
        hin2 = IV224;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!valid2 && cyc < 100);
        chk("sha224 latency", 1024'(cyc), 1024'(65));
        chk("sha224 digest", 1024'(hout2 & M224), 1024'(pop256() & M224));

        chk("scoreboard drained", 1024'(sb.size() + sb5.size()), 1024'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
